// File: rtl/regbank_pkg.sv
// Shared types and defaults for the multi-port register bank.
// Covers both builds (REGBANK_BYPASS_EN undefined or defined).
package regbank_pkg;

  localparam int unsigned RB_DATA_W   = 64;
  localparam int unsigned RB_ADDR_W   = 5;
  localparam int unsigned RB_ZERO_REG = 31;

  typedef enum logic {
    RB_IDLE,
    RB_CLEAR
  } rb_state_e;

  // True when the configured zero register lies inside the bank.
  function automatic bit rb_zero_en(input int unsigned zero_reg, input int unsigned addr_w);
    return zero_reg < (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/regbank_clear_fsm.sv
// Bulk-clear sequencer: walks every bank index once, one per cycle, with a registered busy.
// Unaffected by REGBANK_BYPASS_EN.
module regbank_clear_fsm
  import regbank_pkg::*;
#(
  parameter int unsigned ADDR_W = RB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  rb_state_e         r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;

  // The counter is ADDR_W wide, so stepping past DEPTH-1 wraps it back to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RB_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        RB_IDLE: begin
          if (clear_req) begin
            r_state <= RB_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RB_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= RB_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= RB_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign clr_en   = (r_state == RB_CLEAR);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register file: NUM_READ combinational reads, two prioritised writes, zero register,
// bulk clear. Define REGBANK_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_bank_mp
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W   = RB_DATA_W,
  parameter int unsigned ADDR_W   = RB_ADDR_W,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned ZERO_REG = RB_ZERO_REG
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_en0,
  input  logic [ADDR_W-1:0]            wr_addr0,
  input  logic [DATA_W-1:0]            wr_data0,
  input  logic                         wr_en1,
  input  logic [ADDR_W-1:0]            wr_addr1,
  input  logic [DATA_W-1:0]            wr_data1,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  input  logic                         clear_req,
  output logic                         busy
);

  localparam int unsigned     DEPTH    = 32'd1 << ADDR_W;
  localparam bit              ZeroEn   = rb_zero_en(ZERO_REG, ADDR_W);
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic              w_busy;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_we0;
  logic              w_we1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  regbank_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .busy      (w_busy),
    .clr_en    (w_clr_en),
    .clr_addr  (w_clr_addr)
  );

  assign busy = w_busy;

  // Port 1 is suppressed on a same-address collision so port 0 always wins.
  assign w_we0 = wr_en0 && !w_busy && !(ZeroEn && (wr_addr0 == ZeroAddr));
  assign w_we1 = wr_en1 && !w_busy && !(ZeroEn && (wr_addr1 == ZeroAddr)) &&
                 !(w_we0 && (wr_addr0 == wr_addr1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_clr_en) begin
        r_mem[w_clr_addr] <= '0;
      end
      if (w_we1) begin
        r_mem[wr_addr1] <= wr_data1;
      end
      if (w_we0) begin
        r_mem[wr_addr0] <= wr_data0;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
`ifdef REGBANK_BYPASS_EN
      if (w_we0 && (w_addr == wr_addr0)) begin
        w_data = wr_data0;
      end else if (w_we1 && (w_addr == wr_addr1)) begin
        w_data = wr_data1;
      end
`endif
      if (ZeroEn && (w_addr == ZeroAddr)) begin
        w_data = '0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_data;
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Randomised self-checking bench for register_bank_mp against an array-based reference model.
module tb_register_bank_mp;

  logic        clock;
  logic        reset_n;
  logic        wr_en0;
  logic [4:0]  wr_addr0;
  logic [63:0] wr_data0;
  logic        wr_en1;
  logic [4:0]  wr_addr1;
  logic [63:0] wr_data1;
  logic [9:0]  rd_addr;
  logic [127:0] rd_data;
  logic        clear_req;
  logic        busy;

  int n_tests;
  int n_fail;

  logic [63:0] ref_mem [32];
  bit          ref_busy;
  int          ref_idx;

  register_bank_mp #(
    .DATA_W   (64),
    .ADDR_W   (5),
    .NUM_READ (2),
    .ZERO_REG (31)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en0    (wr_en0),
    .wr_addr0  (wr_addr0),
    .wr_data0  (wr_data0),
    .wr_en1    (wr_en1),
    .wr_addr1  (wr_addr1),
    .wr_data1  (wr_data1),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .clear_req (clear_req),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] exp_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
`ifdef REGBANK_BYPASS_EN
    if (!ref_busy && wr_en0 && wr_addr0 == a) return wr_data0;
    if (!ref_busy && wr_en1 && wr_addr1 == a) return wr_data1;
`endif
    return ref_mem[a];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
    ref_busy = 1'b0;
    ref_idx  = 0;
  endfunction

  // Effect of one rising edge given the inputs currently driven.
  function automatic void model_edge();
    if (ref_busy) begin
      ref_mem[ref_idx] = 64'd0;
      ref_idx++;
      if (ref_idx == 32) begin
        ref_busy = 1'b0;
        ref_idx  = 0;
      end
    end else begin
      if (wr_en1 && wr_addr1 != 5'd31) ref_mem[wr_addr1] = wr_data1;
      if (wr_en0 && wr_addr0 != 5'd31) ref_mem[wr_addr0] = wr_data0;
      if (clear_req) begin
        ref_busy = 1'b1;
        ref_idx  = 0;
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en0    = 1'b0;
    wr_en1    = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wr_addr0 = '0; wr_data0 = '0; wr_addr1 = '0; wr_data1 = '0; rd_addr = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (rd_data[k*64 +: 64] !== 64'd0) begin
          n_fail++;
          $display("FAIL reset_read port%0d addr%0d: got %h expected 0", k, a,
                   rd_data[k*64 +: 64]);
        end
      end
    end
  endtask

  task automatic test_basic_write();
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 64'hDEAD_BEEF_0000_0001;
    tick();
    wr_en0 = 1'b1; wr_addr0 = 5'd31; wr_data0 = 64'h55;
    rd_addr = {5'd31, 5'd3};
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_data[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL write_addr3: got %h expected %h", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    end
    n_tests++;
    if (rd_data[127:64] !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_reg_write: got %h expected 0", rd_data[127:64]);
    end
  endtask

  task automatic test_collision();
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 64'h11;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 64'h22;
    tick();
    wr_addr0 = 5'd4; wr_data0 = 64'hA;
    wr_addr1 = 5'd5; wr_data1 = 64'hB;
    tick();
    idle_inputs();
    rd_addr = {5'd4, 5'd7};
    #1;
    n_tests++;
    if (rd_data[63:0] !== 64'h11) begin
      n_fail++;
      $display("FAIL collision_addr7: got %h expected 11", rd_data[63:0]);
    end
    n_tests++;
    if (rd_data[127:64] !== 64'hA) begin
      n_fail++;
      $display("FAIL dual_write_addr4: got %h expected a", rd_data[127:64]);
    end
    rd_addr = {5'd5, 5'd5};
    #1;
    n_tests++;
    if (rd_data[127:64] !== 64'hB) begin
      n_fail++;
      $display("FAIL dual_write_addr5: got %h expected b", rd_data[127:64]);
    end
  endtask

  task automatic test_bypass();
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 64'h33;
    tick();
    wr_data0 = 64'h77;
    rd_addr  = {5'd9, 5'd0};
    #1;
    n_tests++;
`ifdef REGBANK_BYPASS_EN
    if (rd_data[127:64] !== 64'h77) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got %h expected 77", rd_data[127:64]);
    end
`else
    if (rd_data[127:64] !== 64'h33) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got %h expected 33", rd_data[127:64]);
    end
`endif
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_data[127:64] !== 64'h77) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: got %h expected 77", rd_data[127:64]);
    end
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 0; i < 31; i++) begin
      wr_en0 = 1'b1; wr_addr0 = i[4:0]; wr_data0 = 64'(i);
      tick();
    end
    // Same-edge write commits before the clear reaches it.
    wr_en0 = 1'b1; wr_addr0 = 5'd20; wr_data0 = 64'hABC;
    clear_req = 1'b1;
    tick();
    idle_inputs();
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      wr_en0 = (cnt == 5);
      wr_addr0 = 5'd2; wr_data0 = 64'h99;
      clear_req = (cnt == 7);
      rd_addr = (cnt == 5) ? {5'd20, 5'd30} : {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (rd_data[k*64 +: 64] !== exp_read(rd_addr[k*5 +: 5])) begin
          n_fail++;
          $display("FAIL clear_read cyc%0d port%0d: got %h expected %h", cnt, k,
                   rd_data[k*64 +: 64], exp_read(rd_addr[k*5 +: 5]));
        end
      end
      tick();
      cnt++;
    end
    idle_inputs();
    n_tests++;
    if (cnt != 32) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d expected 32", cnt);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      #1;
      n_tests++;
      if (rd_data[63:0] !== 64'd0 || ref_mem[a] !== 64'd0) begin
        n_fail++;
        $display("FAIL clear_final addr%0d: got %h expected 0", a, rd_data[63:0]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    for (int i = 0; i < 31; i++) begin
      wr_en0 = 1'b1; wr_addr0 = i[4:0]; wr_data0 = {$urandom, $urandom};
      tick();
    end
    wr_en0 = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear_busy: got %b expected 0", busy);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[4:0], 5'(31 - a)};
      #0.1;
      n_tests++;
      if (rd_data !== 128'd0) begin
        n_fail++;
        $display("FAIL reset_mid_clear_read addr%0d: got %h expected 0", a, rd_data);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt != 32 || ref_busy) begin
      n_fail++;
      $display("FAIL reclear_busy_len: got %0d expected 32", cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en0    = ($urandom_range(0, 3) != 0);
      wr_addr0  = 5'($urandom_range(0, 31));
      wr_data0  = {$urandom, $urandom};
      wr_en1    = ($urandom_range(0, 3) != 0);
      wr_addr1  = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
      wr_data1  = {$urandom, $urandom};
      clear_req = ($urandom_range(0, 59) == 0);
      rd_addr   = ($urandom_range(0, 1) == 0) ? {wr_addr1, wr_addr0}
                                              : {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      #1;
      n_tests++;
      if (busy !== ref_busy) begin
        n_fail++;
        $display("FAIL random_busy cyc%0d: got %b expected %b", c, busy, ref_busy);
      end
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (rd_data[k*64 +: 64] !== exp_read(rd_addr[k*5 +: 5])) begin
          n_fail++;
          $display("FAIL random_read cyc%0d port%0d addr%0d: got %h expected %h", c, k,
                   rd_addr[k*5 +: 5], rd_data[k*64 +: 64], exp_read(rd_addr[k*5 +: 5]));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_write();
    test_collision();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
